// File: rtl/config_pkg.sv
// Shared types and sizing helpers for the FP/integer divide-sqrt arbiter.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } stateT;

  localparam int MAXCYC_DEFAULT = 64;
  localparam int CNT_W          = $clog2(MAXCYC_DEFAULT);

  // Watchdog counter width for an arbitrary limit; never narrower than one bit.
  function automatic int cntWidth(input int maxCyc);
    return (maxCyc > 1) ? $clog2(maxCyc) : 1;
  endfunction

endpackage

// File: rtl/fdivsqrt_arb_if.sv
// Request/response bus between the FP and integer requesters and the divide-sqrt arbiter.
interface fdivsqrt_arb_if #(
  parameter int TAGW = 5
);

  logic            FReqValid;
  logic            FReqSqrt;
  logic [TAGW-1:0] FReqTag;
  logic            FReqReady;

  logic            IReqValid;
  logic [TAGW-1:0] IReqTag;
  logic            IReqReady;

  logic            RespValid;
  logic            RespInt;
  logic [TAGW-1:0] RespTag;
  logic            RespReady;

  modport slave (
    input  FReqValid, FReqSqrt, FReqTag,
    output FReqReady,
    input  IReqValid, IReqTag,
    output IReqReady,
    output RespValid, RespInt, RespTag,
    input  RespReady
  );

  modport master (
    output FReqValid, FReqSqrt, FReqTag,
    input  FReqReady,
    output IReqValid, IReqTag,
    input  IReqReady,
    input  RespValid, RespInt, RespTag,
    output RespReady
  );

endinterface

// File: rtl/fdivsqrt_rrgrant.sv
// Two-way round-robin grant: on contention the requester that was not served last wins.
module fdivsqrt_rrgrant (
  input  logic fReq,
  input  logic iReq,
  input  logic rrLast,
  output logic grantF,
  output logic grantI
);

  // rrLast = 1 means the integer side was served last, so FP goes next.
  always_comb begin
    grantF = 1'b0;
    grantI = 1'b0;
    if (fReq && iReq) begin
      grantF = rrLast;
      grantI = !rrLast;
    end else begin
      grantF = fReq;
      grantI = iReq;
    end
  end

endmodule

// File: rtl/fdivsqrt_arb.sv
// Arbitrates FP divide/sqrt and integer divide requests onto one shared divider.
// Define FDIVSQRT_IDIV_EN to enable the integer requester; otherwise only FP is served.
module fdivsqrt_arb
  import config_pkg::*;
#(
  parameter int TAGW   = 5,
  parameter int MAXCYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  fdivsqrt_arb_if.slave        bus,
  input  logic                 Flush,
  output logic                 FDivStartE,
  output logic                 IDivStartE,
  output logic                 SqrtE,
  input  logic                 FDivBusyE,
  input  logic                 FDivDoneE,
  output logic                 StallM,
  output logic                 Timeout
);

  localparam int             CW      = cntWidth(MAXCYC);
  localparam logic [CW-1:0]  CNTLAST = CW'(MAXCYC - 1);

  stateT           state;
  stateT           nxt;
  logic [CW-1:0]   cnt;
  logic            kindInt;
  logic            sqrtReg;
  logic [TAGW-1:0] tagReg;
  logic            rrLast;

  logic            grantF;
  logic            grantI;
  logic            iReqGated;
  logic            accept;
  logic            rrUpd;
  logic            tmo;
  logic            live;
  logic            unusedInputs;

`ifdef FDIVSQRT_IDIV_EN
  assign iReqGated    = bus.IReqValid;
  assign unusedInputs = FDivBusyE;
`else
  assign iReqGated    = 1'b0;
  assign unusedInputs = ^{FDivBusyE, bus.IReqValid};
`endif

  fdivsqrt_rrgrant uGrant (
    .fReq   (bus.FReqValid),
    .iReq   (iReqGated),
    .rrLast (rrLast),
    .grantF (grantF),
    .grantI (grantI)
  );

  assign accept = (state == IDLE) && !Flush && (grantF || grantI);

  // Next-state logic; Flush beats done in BUSY, done beats the watchdog.
  always_comb begin
    nxt   = state;
    rrUpd = 1'b0;
    tmo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) nxt = START;
      end
      START: begin
        if (Flush) begin
          nxt   = IDLE;
          rrUpd = 1'b1;
        end else begin
          nxt = BUSY;
        end
      end
      BUSY: begin
        if (Flush) begin
          nxt   = IDLE;
          rrUpd = 1'b1;
        end else if (FDivDoneE) begin
          nxt = HOLD;
        end else if (cnt == CNTLAST) begin
          nxt   = IDLE;
          rrUpd = 1'b1;
          tmo   = 1'b1;
        end
      end
      HOLD: begin
        if (bus.RespReady) begin
          nxt   = IDLE;
          rrUpd = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      kindInt <= 1'b0;
      sqrtReg <= 1'b0;
      tagReg  <= '0;
      rrLast  <= 1'b1;
    end else begin
      state <= nxt;
      if (accept) begin
        kindInt <= grantI;
        sqrtReg <= grantI ? 1'b0 : bus.FReqSqrt;
        tagReg  <= grantI ? bus.IReqTag : bus.FReqTag;
      end
      if (state == START) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (rrUpd) rrLast <= kindInt;
    end
  end

  // Every output is forced low while reset is asserted, even mid-operation.
  assign live          = !reset;
  assign bus.FReqReady = live && accept && grantF;
  assign FDivStartE    = live && (state == START) && !kindInt;
  assign SqrtE         = live && (state == START) && sqrtReg;
  assign bus.RespValid = live && (state == HOLD);
  assign bus.RespTag   = (live && (state == HOLD)) ? tagReg : '0;
  assign StallM        = live && (state == HOLD) && !bus.RespReady;
  assign Timeout       = live && tmo;

`ifdef FDIVSQRT_IDIV_EN
  assign bus.IReqReady = live && accept && grantI;
  assign IDivStartE    = live && (state == START) && kindInt;
  assign bus.RespInt   = live && (state == HOLD) && kindInt;
`else
  assign bus.IReqReady = 1'b0;
  assign IDivStartE    = 1'b0;
  assign bus.RespInt   = 1'b0;
`endif

endmodule

// File: tb/tb_fdivsqrt_arb.sv
// Directed-vector bench for fdivsqrt_arb (MAXCYC = 8); integer expectations follow FDIVSQRT_IDIV_EN.
module tb_fdivsqrt_arb;
  localparam int TAGW = 5;

  logic clk = 1'b0;
  logic reset;
  logic Flush;
  logic FDivStartE, IDivStartE, SqrtE;
  logic FDivBusyE, FDivDoneE;
  logic StallM, Timeout;

  int passCnt  = 0;
  int checkCnt = 0;

  fdivsqrt_arb_if #(.TAGW(TAGW)) bus ();

  fdivsqrt_arb #(.TAGW(TAGW), .MAXCYC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .Flush      (Flush),
    .FDivStartE (FDivStartE),
    .IDivStartE (IDivStartE),
    .SqrtE      (SqrtE),
    .FDivBusyE  (FDivBusyE),
    .FDivDoneE  (FDivDoneE),
    .StallM     (StallM),
    .Timeout    (Timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    bus.FReqValid = 1'b0;
    bus.FReqSqrt  = 1'b0;
    bus.FReqTag   = '0;
    bus.IReqValid = 1'b0;
    bus.IReqTag   = '0;
    bus.RespReady = 1'b0;
    Flush         = 1'b0;
    FDivBusyE     = 1'b0;
    FDivDoneE     = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearIn();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Runs one FP operation from an IDLE cycle through the response handshake.
  task automatic serveFp(input logic [TAGW-1:0] tag);
    bus.FReqValid = 1'b1;
    bus.FReqTag   = tag;
    cyc();
    bus.FReqValid = 1'b0;
    cyc();
    FDivDoneE = 1'b1;
    cyc();
    FDivDoneE     = 1'b0;
    bus.RespReady = 1'b1;
    cyc();
    bus.RespReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearIn();
    bus.FReqValid = 1'b1;
    cyc();
    #1;
    checkCnt++;
    if (bus.FReqReady !== 1'b0) $display("FAIL reset_fready: got %b want 0", bus.FReqReady); else passCnt++;
    checkCnt++;
    if ({bus.RespValid, StallM, Timeout, FDivStartE} !== 4'b0000)
      $display("FAIL reset_outs: got %b want 0000", {bus.RespValid, StallM, Timeout, FDivStartE});
    else passCnt++;
    cyc();
    reset = 1'b0;
    bus.FReqValid = 1'b0;
  endtask

  task automatic test_fp_basic();
    doReset();
    bus.FReqValid = 1'b1;
    bus.FReqTag   = 5'd3;
    bus.FReqSqrt  = 1'b1;
    #1;
    checkCnt++;
    if ({bus.FReqReady, bus.IReqReady} !== 2'b10)
      $display("FAIL basic_ready: got %b want 10", {bus.FReqReady, bus.IReqReady});
    else passCnt++;
    cyc();
    bus.FReqValid = 1'b0;
    bus.FReqSqrt  = 1'b0;
    #1;
    checkCnt++;
    if ({FDivStartE, IDivStartE, SqrtE, bus.FReqReady} !== 4'b1010)
      $display("FAIL basic_start: got %b want 1010", {FDivStartE, IDivStartE, SqrtE, bus.FReqReady});
    else passCnt++;
    cyc();
    FDivDoneE = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, FDivStartE} !== 2'b00)
      $display("FAIL basic_busy: got %b want 00", {bus.RespValid, FDivStartE});
    else passCnt++;
    cyc();
    FDivDoneE     = 1'b0;
    bus.RespReady = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, bus.RespInt, bus.RespTag, StallM} !== {1'b1, 1'b0, 5'd3, 1'b0})
      $display("FAIL basic_resp: got v=%b i=%b t=%0d s=%b want v=1 i=0 t=3 s=0",
               bus.RespValid, bus.RespInt, bus.RespTag, StallM);
    else passCnt++;
    cyc();
    bus.RespReady = 1'b0;
    #1;
    checkCnt++;
    if (bus.RespValid !== 1'b0) $display("FAIL basic_idle: got %b want 0", bus.RespValid); else passCnt++;
  endtask

  task automatic test_round_robin();
    doReset();
    bus.FReqValid = 1'b1;
    bus.FReqTag   = 5'd4;
    bus.IReqValid = 1'b1;
    bus.IReqTag   = 5'd12;
    #1;
    checkCnt++;
    if ({bus.FReqReady, bus.IReqReady} !== 2'b10)
      $display("FAIL rr_first: got %b want 10", {bus.FReqReady, bus.IReqReady});
    else passCnt++;
    cyc();
    bus.FReqValid = 1'b0;
    bus.IReqValid = 1'b0;
    cyc();
    FDivDoneE = 1'b1;
    cyc();
    FDivDoneE     = 1'b0;
    bus.RespReady = 1'b1;
    cyc();
    bus.RespReady = 1'b0;
    bus.FReqValid = 1'b1;
    bus.IReqValid = 1'b1;
    #1;
`ifdef FDIVSQRT_IDIV_EN
    checkCnt++;
    if ({bus.FReqReady, bus.IReqReady} !== 2'b01)
      $display("FAIL rr_second: got %b want 01", {bus.FReqReady, bus.IReqReady});
    else passCnt++;
    cyc();
    bus.FReqValid = 1'b0;
    bus.IReqValid = 1'b0;
    #1;
    checkCnt++;
    if ({FDivStartE, IDivStartE, SqrtE} !== 3'b010)
      $display("FAIL rr_istart: got %b want 010", {FDivStartE, IDivStartE, SqrtE});
    else passCnt++;
    cyc();
    FDivDoneE = 1'b1;
    cyc();
    FDivDoneE     = 1'b0;
    bus.RespReady = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, bus.RespInt, bus.RespTag} !== {1'b1, 1'b1, 5'd12})
      $display("FAIL rr_iresp: got v=%b i=%b t=%0d want v=1 i=1 t=12", bus.RespValid, bus.RespInt, bus.RespTag);
    else passCnt++;
`else
    checkCnt++;
    if ({bus.FReqReady, bus.IReqReady} !== 2'b10)
      $display("FAIL rr_second: got %b want 10", {bus.FReqReady, bus.IReqReady});
    else passCnt++;
    cyc();
    bus.FReqValid = 1'b0;
    bus.IReqValid = 1'b0;
    #1;
    checkCnt++;
    if ({FDivStartE, IDivStartE} !== 2'b10)
      $display("FAIL rr_fstart: got %b want 10", {FDivStartE, IDivStartE});
    else passCnt++;
    cyc();
    FDivDoneE = 1'b1;
    cyc();
    FDivDoneE     = 1'b0;
    bus.RespReady = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, bus.RespInt, bus.RespTag} !== {1'b1, 1'b0, 5'd4})
      $display("FAIL rr_fresp: got v=%b i=%b t=%0d want v=1 i=0 t=4", bus.RespValid, bus.RespInt, bus.RespTag);
    else passCnt++;
`endif
    cyc();
    bus.RespReady = 1'b0;
  endtask

  task automatic test_hold_stall();
    doReset();
    bus.FReqValid = 1'b1;
    bus.FReqTag   = 5'd7;
    cyc();
    bus.FReqValid = 1'b0;
    cyc();
    FDivDoneE = 1'b1;
    cyc();
    FDivDoneE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Flush = (i == 1);
      #1;
      checkCnt++;
      if ({bus.RespValid, StallM, bus.RespInt, bus.RespTag} !== {1'b1, 1'b1, 1'b0, 5'd7})
        $display("FAIL hold_stall%0d: got v=%b s=%b i=%b t=%0d want v=1 s=1 i=0 t=7",
                 i, bus.RespValid, StallM, bus.RespInt, bus.RespTag);
      else passCnt++;
      cyc();
    end
    Flush         = 1'b0;
    bus.RespReady = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, StallM} !== 2'b10)
      $display("FAIL hold_release: got %b want 10", {bus.RespValid, StallM});
    else passCnt++;
    cyc();
    bus.RespReady = 1'b0;
    bus.FReqValid = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, bus.FReqReady} !== 2'b01)
      $display("FAIL hold_idle: got %b want 01", {bus.RespValid, bus.FReqReady});
    else passCnt++;
    bus.FReqValid = 1'b0;
  endtask

  task automatic test_flush();
    doReset();
    bus.FReqValid = 1'b1;
    Flush         = 1'b1;
    #1;
    checkCnt++;
    if (bus.FReqReady !== 1'b0) $display("FAIL flush_idle_ready: got %b want 0", bus.FReqReady); else passCnt++;
    Flush = 1'b0;
    bus.FReqTag = 5'd9;
    cyc();
    bus.FReqValid = 1'b0;
    cyc();
    Flush     = 1'b1;
    FDivDoneE = 1'b1;
    cyc();
    Flush         = 1'b0;
    FDivDoneE     = 1'b0;
    bus.FReqValid = 1'b1;
    bus.FReqTag   = 5'd2;
    #1;
    checkCnt++;
    if ({bus.RespValid, StallM, bus.FReqReady} !== 3'b001)
      $display("FAIL flush_done: got %b want 001", {bus.RespValid, StallM, bus.FReqReady});
    else passCnt++;
    cyc();
    bus.FReqValid = 1'b0;
    #1;
    checkCnt++;
    if (FDivStartE !== 1'b1) $display("FAIL flush_restart: got %b want 1", FDivStartE); else passCnt++;
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
  endtask

  task automatic test_timeout();
    doReset();
    bus.FReqValid = 1'b1;
    cyc();
    bus.FReqValid = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      #1;
      checkCnt++;
      if (Timeout !== (i == 7)) $display("FAIL timeout_busy%0d: got %b want %b", i, Timeout, (i == 7));
      else passCnt++;
      cyc();
    end
    bus.FReqValid = 1'b1;
    #1;
    checkCnt++;
    if ({Timeout, bus.RespValid, bus.FReqReady} !== 3'b001)
      $display("FAIL timeout_idle: got %b want 001", {Timeout, bus.RespValid, bus.FReqReady});
    else passCnt++;
    bus.FReqValid = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    doReset();
    serveFp(5'd1);
    bus.FReqValid = 1'b1;
    bus.FReqTag   = 5'd5;
    cyc();
    bus.FReqValid = 1'b0;
    cyc();
    FDivDoneE = 1'b1;
    cyc();
    FDivDoneE = 1'b0;
    #1;
    checkCnt++;
    if ({bus.RespValid, StallM} !== 2'b11) $display("FAIL rsthold_pre: got %b want 11", {bus.RespValid, StallM});
    else passCnt++;
    reset = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, StallM, bus.RespTag} !== 7'd0)
      $display("FAIL rsthold_during: got v=%b s=%b t=%0d want 0", bus.RespValid, StallM, bus.RespTag);
    else passCnt++;
    cyc();
    reset         = 1'b0;
    bus.RespReady = 1'b1;
    bus.FReqValid = 1'b1;
    bus.IReqValid = 1'b1;
    #1;
    checkCnt++;
    if ({bus.RespValid, bus.FReqReady, bus.IReqReady} !== 3'b010)
      $display("FAIL rsthold_after: got %b want 010", {bus.RespValid, bus.FReqReady, bus.IReqReady});
    else passCnt++;
    cyc();
    clearIn();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clearIn();
    test_reset();
    test_fp_basic();
    test_round_robin();
    test_hold_stall();
    test_flush();
    test_timeout();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_arb.md
FDIVSQRT_ARB -- requirements
Module: fdivsqrt_arb

Interface
REQ-001 The block SHALL have parameter TAGW, default 5, the width of the requester tag (destination register).
REQ-002 The block SHALL have parameter MAXCYC, default 64, the watchdog limit in BUSY cycles.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 FReqValid  input  1  FPU requests a divide or square root.
REQ-006 FReqSqrt  input  1  FPU request is a square root (0 = divide).
REQ-007 FReqTag  input  TAGW  FPU request tag.
REQ-008 FReqReady  output  1  FPU request accepted this cycle.
REQ-009 IReqValid  input  1  integer unit requests a divide or remainder.
REQ-010 IReqTag  input  TAGW  integer request tag.
REQ-011 IReqReady  output  1  integer request accepted this cycle.
REQ-012 Flush  input  1  abort the in-flight operation.
REQ-013 FDivStartE / IDivStartE / SqrtE  output  1 each  start pulses and sqrt select to the divider.
REQ-014 FDivBusyE, FDivDoneE  input  1 each  divider status.
REQ-015 StallM  output  1  freezes the divider result while the response is unaccepted.
REQ-016 RespValid  output  1; RespInt  output  1 (1 = integer); RespTag  output  TAGW; RespReady  input  1.
REQ-017 Timeout  output  1  one-cycle watchdog pulse.

Function
REQ-018 The FSM SHALL have states IDLE, START, BUSY and HOLD.
REQ-019 In IDLE with Flush low, the block SHALL grant one valid requester, assert only that requester's Ready combinationally in the same cycle, latch kind, sqrt and tag, and go to START.
REQ-020 When both requesters are valid, the grant SHALL go to the requester opposite to rrLast, a 1-bit round-robin pointer.
REQ-021 Ready outputs SHALL be 0 in every state except IDLE, and 0 whenever Flush is high.
REQ-022 START SHALL last one cycle and pulse exactly one of FDivStartE or IDivStartE, with SqrtE equal to the latched sqrt bit (0 for integer); the next state SHALL be BUSY.
REQ-023 BUSY SHALL increment a cycle counter, cleared on entry; on FDivDoneE the FSM SHALL go to HOLD.
REQ-024 HOLD SHALL assert RespValid with the latched RespInt and RespTag, and assert StallM while RespReady is 0.
REQ-025 In HOLD, RespValid && RespReady SHALL return the FSM to IDLE and set rrLast to the served requester.
REQ-026 Flush in START or BUSY SHALL return the FSM to IDLE next cycle with no response; rrLast SHALL still update.
REQ-027 Flush in HOLD SHALL be ignored.
REQ-028 When Flush and FDivDoneE are both high in BUSY, Flush SHALL win.
REQ-029 When the counter reaches MAXCYC-1 in BUSY without FDivDoneE, the block SHALL pulse Timeout for one cycle, return to IDLE and update rrLast.
REQ-030 Minimum latency from request acceptance to RespValid SHALL be 2 cycles plus the divider's done latency.

Reset
REQ-031 On reset the block SHALL enter IDLE, clear the counter, latched kind, sqrt and tag, and set rrLast = 1 so that FP has first priority.
REQ-032 All outputs SHALL be 0 during reset, including a reset asserted mid-operation; no response SHALL follow a reset.

Configuration
REQ-033 With macro FDIVSQRT_IDIV_EN defined, the integer requester SHALL be arbitrated as above.
REQ-034 With FDIVSQRT_IDIV_EN undefined, IReqReady, IDivStartE and RespInt SHALL be tied 0, IReqValid SHALL be ignored, and FP requests SHALL be granted without arbitration.

Structure
REQ-035 The state enum (IDLE/START/BUSY/HOLD) SHALL be defined as a typedef in config_pkg, alongside the counter width constant, which SHALL be clog2 of MAXCYC.
REQ-036 The round-robin grant logic SHALL be a single sub-module, fdivsqrt_rrgrant.

Verification
REQ-037 FReqValid=1 with FReqTag=3 and FReqSqrt=1 alone -> FReqReady=1 same cycle; FDivStartE and SqrtE pulse next cycle; FDivDoneE=1 -> RespValid=1 with RespInt=0 and RespTag=3.
REQ-038 FReqValid and IReqValid both high after reset, then both again -> first grant to FP, second grant to integer.
REQ-039 HOLD with RespReady=0 for 4 cycles -> StallM=1 and RespValid=1 held for 4 cycles, fields stable; return to IDLE the cycle after RespReady=1.
REQ-040 Flush and FDivDoneE high together in BUSY -> no RespValid; IDLE next cycle; a new request is accepted that cycle.
REQ-041 MAXCYC=8 with FDivDoneE never asserted -> Timeout pulses after 8 BUSY cycles, then IDLE.
REQ-042 Reset asserted in HOLD -> all outputs 0 next cycle, and the next simultaneous request goes to FP.
